matmult_sequencer: RTL and testbench

Parametrised run sequencer for the matrix-multiply top level. It debounces and edge-detects a raw active-low start button and fans a one-cycle start out to NUM_UNITS parallel compute units. It collects each unit's done, repeats the launch for a programmable batch of runs, and reports completion, run count and elapsed cycles. It sits between the board keys and the compute_unit array and replaces the single-unit, single-run start logic.

---
 rtl/matmult_sequencer.sv | 169 ++++++++++++++++
 tb/tb_matmult_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/matmult_sequencer.sv
// Run sequencer: debounced start key, parallel unit launch, batch repeat, busy-cycle counter.
// Optional per-run watchdog enabled by defining SEQ_TIMEOUT_EN.
module matmult_sequencer #(
  parameter int unsigned NUM_UNITS       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned RUN_W           = 8,
  parameter int unsigned CYC_W           = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 65536
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_start_n,
  input  logic [RUN_W-1:0]     run_count,
  output logic [NUM_UNITS-1:0] unit_start,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [RUN_W-1:0]     runs_done,
  output logic [CYC_W-1:0]     cycle_count
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StCheck} state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, key_sync_q;
  logic                 key_stable_q, key_stable_d, key_prev_q;
  logic [DbW-1:0]       db_cnt_q, db_cnt_d;
  logic [RUN_W-1:0]     target_q, target_d, runs_q, runs_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [NUM_UNITS-1:0] seen_q, seen_d;
  logic                 done_q, done_d;
  logic                 start_req, all_seen;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYCLES - 1);
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           error_q, error_d;
`endif

  // Counter only runs while the synchronised key disagrees with the accepted level.
  always_comb begin
    db_cnt_d     = db_cnt_q;
    key_stable_d = key_stable_q;
    if (key_sync_q == key_stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbMax) begin
      key_stable_d = key_sync_q;
      db_cnt_d     = '0;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  assign start_req = key_stable_q & ~key_prev_q;
  assign all_seen  = &(seen_q | unit_done);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    runs_d   = runs_q;
    cyc_d    = cyc_q;
    seen_d   = seen_q;
    done_d   = done_q;
`ifdef SEQ_TIMEOUT_EN
    wdog_d   = wdog_q;
    error_d  = error_q;
`endif
    if ((state_q != StIdle) && !(&cyc_q)) begin
      cyc_d = cyc_q + CYC_W'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          target_d = (run_count == '0) ? RUN_W'(1) : run_count;
          runs_d   = '0;
          cyc_d    = '0;
          done_d   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
          error_d  = 1'b0;
`endif
          state_d  = StLaunch;
        end
      end
      StLaunch: begin
        seen_d  = '0;
`ifdef SEQ_TIMEOUT_EN
        wdog_d  = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        seen_d = seen_q | unit_done;
        if (all_seen) begin
          state_d = StCheck;
`ifdef SEQ_TIMEOUT_EN
        end else if (wdog_q == WdMax) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + WdW'(1);
`endif
        end
      end
      StCheck: begin
        runs_d = runs_q + RUN_W'(1);
        if (runs_d == target_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StLaunch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sync1_q      <= 1'b0;
      key_sync_q   <= 1'b0;
      key_stable_q <= 1'b0;
      key_prev_q   <= 1'b0;
      db_cnt_q     <= '0;
      target_q     <= '0;
      runs_q       <= '0;
      cyc_q        <= '0;
      seen_q       <= '0;
      done_q       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wdog_q       <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= ~key_start_n;
      key_sync_q   <= sync1_q;
      key_stable_q <= key_stable_d;
      key_prev_q   <= key_stable_q;
      db_cnt_q     <= db_cnt_d;
      target_q     <= target_d;
      runs_q       <= runs_d;
      cyc_q        <= cyc_d;
      seen_q       <= seen_d;
      done_q       <= done_d;
`ifdef SEQ_TIMEOUT_EN
      wdog_q       <= wdog_d;
      error_q      <= error_d;
`endif
    end
  end

  assign unit_start  = {NUM_UNITS{state_q == StLaunch}};
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign runs_done   = runs_q;
  assign cycle_count = cyc_q;
`ifdef SEQ_TIMEOUT_EN
  assign error       = error_q;
`else
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_matmult_sequencer.sv
// Directed bench for matmult_sequencer: bounce rejection, batch table, re-press and reset.
module tb_matmult_sequencer;

  localparam int unsigned NU = 4;
  localparam int unsigned DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_start_n;
  logic [7:0]    run_count;
  logic [NU-1:0] unit_start;
  logic [NU-1:0] unit_done;
  logic          busy, done, error;
  logic [7:0]    runs_done;
  logic [31:0]   cycle_count;

  int n_chk  = 0;
  int n_pass = 0;

  // mode 0: all units done 'delay' cycles after launch; 1: staggered bits; 2: unit 2 stuck
  typedef struct {
    logic [7:0] rc;
    int         delay;
    int         mode;
    int         exp_runs;
    int         exp_cyc;
    int         exp_launch;
    int         exp_gap;
    bit         exp_err;
  } vec_t;

  vec_t vecs[$];

  matmult_sequencer #(
    .NUM_UNITS      (NU),
    .DEBOUNCE_CYCLES(DB),
    .RUN_W          (8),
    .CYC_W          (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_start_n(key_start_n),
    .run_count  (run_count),
    .unit_start (unit_start),
    .unit_done  (unit_done),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .runs_done  (runs_done),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_unit_start"}, 32'(unit_start), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_runs_done"}, 32'(runs_done), 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  // Press the key at index 0, model the units cycle by cycle, then release and debounce.
  task automatic run_batch(input vec_t v);
    int since, launches, last_l, first_l;
    bit fin;
    since = -1; launches = 0; last_l = -1; first_l = -1; fin = 0;
    @(negedge clk);
    run_count   = v.rc;
    key_start_n = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      if (k > 0) @(negedge clk);
      if (unit_start != '0) begin
        check("unit_start_val", 32'(unit_start), 32'hF);
        if (launches > 0 && v.exp_gap > 0) check("launch_gap", k - last_l, v.exp_gap);
        if (launches == 0) first_l = k;
        launches++;
        last_l = k;
        since  = 0;
      end else if (since >= 0) begin
        since++;
      end
      case (v.mode)
        0:       unit_done = (since == v.delay) ? 4'hF : 4'h0;
        1:       unit_done = (since >= 1 && since <= 4) ? 4'(1 << (since - 1)) : 4'h0;
        default: unit_done = (since >= 1) ? 4'b1011 : 4'h0;
      endcase
      if (launches > 0 && (done || error)) fin = 1;
    end
    unit_done = '0;
    check("finished", 32'(fin), 1);
    check("first_launch", first_l, 7);
    check("launches", launches, v.exp_launch);
    check("done", 32'(done), 32'(!v.exp_err));
    check("busy_end", 32'(busy), 0);
    check("error", 32'(error), 32'(v.exp_err));
    check("runs_done", 32'(runs_done), v.exp_runs);
    if (v.exp_cyc >= 0) check("cycle_count", cycle_count, v.exp_cyc);
    key_start_n = 1'b1;
    repeat (DB + 4) @(negedge clk);
    check("done_held", 32'(done), 32'(!v.exp_err));
    check("idle_after", 32'(busy), 0);
  endtask

  initial begin
    int starts;
    bit launched;
    rst = 1'b1; key_start_n = 1'b1; run_count = '0; unit_done = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Bounce shorter than the debounce window never starts a run.
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      key_start_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        @(negedge clk);
        if (unit_start != '0 || busy) starts++;
      end
    end
    key_start_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (unit_start != '0 || busy) starts++;
    end
    check("bounce_no_start", starts, 0);

    vecs.push_back('{8'd1, 5, 0, 1, 7, 1, 7, 1'b0});
    vecs.push_back('{8'd1, 0, 1, 1, 6, 1, 0, 1'b0});
    vecs.push_back('{8'd3, 1, 0, 3, 9, 3, 3, 1'b0});
    vecs.push_back('{8'd0, 1, 0, 1, 3, 1, 3, 1'b0});
    vecs.push_back('{8'd2, 3, 0, 2, 10, 2, 5, 1'b0});
    vecs.push_back('{8'd4, 2, 0, 4, 16, 4, 4, 1'b0});
`ifdef SEQ_TIMEOUT_EN
    vecs.push_back('{8'd1, 0, 2, 0, -1, 1, 0, 1'b1});
`endif
    foreach (vecs[i]) run_batch(vecs[i]);

    // Re-press while busy is ignored; reset in WAIT returns everything to zero.
    @(negedge clk);
    run_count   = 8'd1;
    key_start_n = 1'b0;
    launched    = 0;
    for (int k = 0; k < 20 && !launched; k++) begin
      @(negedge clk);
      if (unit_start != '0) launched = 1;
    end
    check("repress_launch", 32'(launched), 1);
    key_start_n = 1'b1;
    starts = 0;
    repeat (7) begin
      @(negedge clk);
      if (unit_start != '0) starts++;
    end
    key_start_n = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (unit_start != '0) starts++;
    end
    check("repress_ignored", starts, 0);
    check("repress_busy", 32'(busy), 1);
    @(negedge clk);
    rst         = 1'b1;
    key_start_n = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    starts = 0;
    repeat (10) begin
      @(negedge clk);
      if (unit_start != '0 || busy) starts++;
    end
    check("post_rst_quiet", starts, 0);
    run_batch('{8'd2, 1, 0, 2, 6, 2, 3, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
